// File: rtl/uart_rx.sv
// UART receiver: start-edge detection, 3-sample majority vote per bit, LSB-first
// data, optional even/odd parity, stop check and one-cycle outcome pulses.
module uart_rx #(
  parameter int Data_length = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic [5:0]             Prescale,
  input  logic                   Parity_Enable,
  input  logic                   Parity_Type,
  output logic [Data_length-1:0] P_Data,
  output logic                   Data_Valid,
  output logic                   Parity_Error,
  output logic                   Stop_Error
);

  localparam int BitW = (Data_length > 1) ? $clog2(Data_length) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(Data_length - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state;
  state_t                 state_nx;

  logic                   prev_rx;
  logic                   armed;
  logic [5:0]             prescale_q;
  logic                   par_en_q;
  logic                   par_type_q;
  logic                   par_err_q;
  logic [5:0]             edge_cnt;
  logic [BitW-1:0]        bit_cnt;
  logic [1:0]             samp;
  logic [Data_length-1:0] shift_q;

  logic [5:0]             half;
  logic                   samp_lo_hit;
  logic                   samp_mid_hit;
  logic                   vote_hit;
  logic                   last_edge;
  logic                   vote;
  logic                   start_det;
  logic                   par_mismatch;
  logic                   fire_dv;
  logic                   fire_pe;
  logic                   fire_se;

  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      6'd8, 6'd16, 6'd32: return p;
      default:            return 6'd8;
    endcase
  endfunction

  assign half         = {1'b0, prescale_q[5:1]};
  assign samp_lo_hit  = (edge_cnt == half - 6'd1);
  assign samp_mid_hit = (edge_cnt == half);
  assign vote_hit     = (edge_cnt == half + 6'd1);
  assign last_edge    = (edge_cnt == prescale_q - 6'd1);
  assign vote         = (samp[0] & samp[1]) | (samp[0] & RX_IN) | (samp[1] & RX_IN);
  assign par_mismatch = vote ^ (^shift_q ^ par_type_q);

  // armed stays low after reset until the line has been seen high, so a line
  // held low through reset release cannot look like a fresh start edge.
  assign start_det    = (state == IDLE) && armed && prev_rx && !RX_IN;

  // NOTE: every signal driven here gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    state_nx = state;
    fire_dv  = 1'b0;
    fire_pe  = 1'b0;
    fire_se  = 1'b0;
    case (state)
      IDLE: begin
        if (start_det) state_nx = START;
      end
      START: begin
        if (vote_hit && vote) state_nx = IDLE;
        else if (last_edge)   state_nx = DATA;
      end
      DATA: begin
        if (last_edge && bit_cnt == LastBit) state_nx = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (last_edge) state_nx = STOP;
      end
      STOP: begin
        if (vote_hit) begin
          state_nx = IDLE;
          if (!vote)          fire_se = 1'b1;
          else if (par_err_q) fire_pe = 1'b1;
          else                fire_dv = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      prev_rx      <= 1'b1;
      armed        <= 1'b0;
      prescale_q   <= 6'd8;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
      par_err_q    <= 1'b0;
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      samp         <= 2'b11;
      // NOTE: the shift register is cleared too, so nothing of an aborted
      // frame survives reset even though it is fully rewritten by every frame.
      shift_q      <= '0;
      P_Data       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      state        <= state_nx;
      prev_rx      <= RX_IN;
      armed        <= armed | RX_IN;
      Data_Valid   <= fire_dv;
      Parity_Error <= fire_pe;
      Stop_Error   <= fire_se;
      if (fire_dv) P_Data <= shift_q;

      if (start_det) begin
        // The detection cycle is edge count 0, so the counter resumes at 1.
        prescale_q <= legal_prescale(Prescale);
        par_en_q   <= Parity_Enable;
        par_type_q <= Parity_Type;
        par_err_q  <= 1'b0;
        edge_cnt   <= 6'd1;
        bit_cnt    <= '0;
      end else if (state != IDLE) begin
        if (state_nx == IDLE || last_edge) edge_cnt <= '0;
        else                               edge_cnt <= edge_cnt + 6'd1;

        if (samp_lo_hit)  samp[0] <= RX_IN;
        if (samp_mid_hit) samp[1] <= RX_IN;

        if (state == DATA) begin
          if (vote_hit) shift_q <= {vote, shift_q[Data_length-1:1]};
          if (last_edge) bit_cnt <= (bit_cnt == LastBit) ? '0 : bit_cnt + 1'b1;
        end

        if (state == PARITY && vote_hit) par_err_q <= par_mismatch;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a vector table of single frames plus hand-written
// sequences for glitch rejection, back-to-back frames, held-low line and reset.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_type;
  logic [7:0] p_data;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;

  uart_rx #(.Data_length(8)) dut (
    .CLK          (clk),
    .RST          (rst),
    .RX_IN        (rx_in),
    .Prescale     (prescale),
    .Parity_Enable(par_en),
    .Parity_Type  (par_type),
    .P_Data       (p_data),
    .Data_Valid   (data_valid),
    .Parity_Error (parity_error),
    .Stop_Error   (stop_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [5:0] presc;
    int         bit_len;
    logic       pen;
    logic       ptype;
    logic       pbit;
    logic       stop;
    logic [2:0] exp_mask;   // {stop, parity, valid}
    logic [7:0] exp_pdata;
    int         exp_off;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [2:0] mask;
    logic [7:0] data;
  } ev_t;

  ev_t  ev_q[$];
  vec_t vecs[9];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with any flag high becomes one event tagged with the cycle index.
  always @(negedge clk)
    if (data_valid || parity_error || stop_error)
      ev_q.push_back('{cyc, {stop_error, parity_error, data_valid}, p_data});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; t is the cycle whose closing edge sees the start bit.
  // Frame settings are scrambled after the first start cycle to prove latching.
  task automatic send_frame(input logic [7:0] d, input logic [5:0] presc, input int len,
                            input logic pen, input logic ptype, input logic pbit,
                            input logic stop, output int t);
    prescale = presc;
    par_en   = pen;
    par_type = ptype;
    t        = cyc;
    rx_in    = 1'b0;
    @(negedge clk);
    prescale = (presc == 6'd8) ? 6'd16 : 6'd8;
    par_en   = ~pen;
    par_type = ~ptype;
    repeat (len - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (len) @(negedge clk);
    end
    if (pen) begin
      rx_in = pbit;
      repeat (len) @(negedge clk);
    end
    rx_in = stop;
    repeat (len) @(negedge clk);
  endtask

  task automatic expect_one(input string name, input int t, input logic [2:0] mask,
                            input logic [7:0] data, input int off);
    check({name, " event count"}, ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      check({name, " flags"}, {29'd0, ev_q[0].mask}, {29'd0, mask});
      check({name, " latency"}, ev_q[0].cyc - t, off);
      check({name, " p_data at pulse"}, {24'd0, ev_q[0].data}, {24'd0, data});
    end
    ev_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t;
    int         t2;
    logic [7:0] b;

    //            data   presc  len pen   ptype pbit  stop  mask    pdata  off
    vecs[0] = '{8'hA5, 6'd8,  8,  1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 8'hA5, 78};
    vecs[1] = '{8'h03, 6'd16, 16, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 8'h03, 170};
    vecs[2] = '{8'h03, 6'd16, 16, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 8'h03, 170};
    vecs[3] = '{8'hFF, 6'd32, 32, 1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 8'hFF, 338};
    vecs[4] = '{8'h55, 6'd32, 32, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 8'hFF, 338};
    vecs[5] = '{8'h3C, 6'd12, 8,  1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 8'h3C, 78};
    vecs[6] = '{8'h81, 6'd8,  8,  1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 8'h3C, 86};
    vecs[7] = '{8'h96, 6'd16, 16, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 8'h96, 154};
    vecs[8] = '{8'h01, 6'd8,  8,  1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 8'h96, 86};

    // Reset with the line held low, and keep it low after release.
    rst      = 1'b1;
    rx_in    = 1'b0;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_type = 1'b0;
    repeat (4) @(negedge clk);
    check("reset p_data", {24'd0, p_data}, 32'd0);
    check("reset flags", {29'd0, stop_error, parity_error, data_valid}, 32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    idle(20);
    check("low at reset release no frame", ev_q.size(), 0);
    check("low at reset release p_data", {24'd0, p_data}, 32'd0);
    ev_q.delete();

    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].data, vecs[i].presc, vecs[i].bit_len, vecs[i].pen,
                 vecs[i].ptype, vecs[i].pbit, vecs[i].stop, t);
      idle(8);
      expect_one($sformatf("vec%0d", i), t, vecs[i].exp_mask, vecs[i].exp_pdata,
                 vecs[i].exp_off);
      check($sformatf("vec%0d p_data after", i), {24'd0, p_data}, {24'd0, vecs[i].exp_pdata});
    end

    // Two-cycle low glitch must be rejected, then a clean frame accepted.
    prescale = 6'd8;
    par_en   = 1'b0;
    rx_in    = 1'b0;
    repeat (2) @(negedge clk);
    idle(30);
    check("glitch no flags", ev_q.size(), 0);
    ev_q.delete();
    send_frame(8'h5A, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, t);
    idle(8);
    expect_one("after glitch", t, 3'b001, 8'h5A, 78);

    // Back-to-back frames with no idle bit between them.
    send_frame(8'h12, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, t);
    send_frame(8'h34, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, t2);
    idle(8);
    check("b2b event count", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      check("b2b first latency", ev_q[0].cyc - t, 78);
      check("b2b spacing", ev_q[1].cyc - ev_q[0].cyc, 80);
      check("b2b first data", {24'd0, ev_q[0].data}, 32'h12);
      check("b2b second data", {24'd0, ev_q[1].data}, 32'h34);
      check("b2b flags", {26'd0, ev_q[1].mask, ev_q[0].mask}, {26'd0, 3'b001, 3'b001});
    end
    ev_q.delete();

    // Stop error with the line left low: exactly one pulse, no retrigger.
    send_frame(8'h55, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0, t);
    repeat (150) @(negedge clk);
    expect_one("held low", t, 3'b100, 8'h34, 78);
    idle(20);
    send_frame(8'h66, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, t);
    idle(8);
    expect_one("after held low", t, 3'b001, 8'h66, 78);

    // Reset during data bit 4 discards the frame silently.
    b        = 8'hC3;
    prescale = 6'd8;
    par_en   = 1'b0;
    rx_in    = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = b[i];
      repeat (8) @(negedge clk);
    end
    rx_in = b[4];
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(120);
    check("mid-frame reset no flags", ev_q.size(), 0);
    check("mid-frame reset p_data", {24'd0, p_data}, 32'd0);
    ev_q.delete();
    send_frame(8'hC3, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, t);
    idle(8);
    expect_one("after reset", t, 3'b001, 8'hC3, 78);
    check("after reset p_data", {24'd0, p_data}, 32'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
